// File: rtl/midi_note_decoder_pkg.sv
// Shared constants for the MIDI note decoder: status nibbles, field widths
// and the parser state encoding.
package midi_note_decoder_pkg;

    localparam int NOTE_W = 7;
    localparam int VEL_W  = 7;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_POLY_AT  = 4'hA;
    localparam logic [3:0] ST_CTRL     = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHAN_AT  = 4'hD;
    localparam logic [3:0] ST_PITCH    = 4'hE;
    localparam logic [3:0] ST_SYSTEM   = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DATA1 = 3'd1,
        S_DATA2 = 3'd2,
        S_SKIP1 = 3'd3,
        S_SKIP2 = 3'd4
    } state_e;

endpackage

// File: rtl/midi_note_decoder_if.sv
// Byte-in / note-event-out bundle between the UART receiver, the decoder
// and the notebank. slave = decoder side, master = byte source / event sink.
interface midi_note_decoder_if #(
    parameter int PERIOD_W = 23
);
    import midi_note_decoder_pkg::*;

    logic [7:0]          rx_data;
    logic                rx_valid;
    logic                note_on;
    logic                note_off;
    logic [PERIOD_W-1:0] period;
    logic [NOTE_W-1:0]   note_num;
    logic [VEL_W-1:0]    velocity;
    logic                active;

    modport master (
        output rx_data, rx_valid,
        input  note_on, note_off, period, note_num, velocity, active
    );

    modport slave (
        input  rx_data, rx_valid,
        output note_on, note_off, period, note_num, velocity, active
    );

endinterface

// File: rtl/midi_note_decoder_period_rom.sv
// Note number -> waveform period in clk cycles, round(CLK_HZ / f(note)).
// Table contents are script-generated for a 4.8 MHz clock; any other CLK_HZ
// reads back as the saturated maximum so a mismatch is obvious on the output.
module midi_note_decoder_period_rom
    import midi_note_decoder_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 4800000,
    parameter int          PERIOD_W = 23
) (
    input  logic [NOTE_W-1:0]   note_i,
    output logic [PERIOD_W-1:0] period_o
);

    localparam bit          TABLE_OK   = (CLK_HZ == 32'd4800000);
    localparam logic [31:0] PERIOD_MAX = (PERIOD_W >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'd1 << PERIOD_W) - 32'd1);

    logic [31:0] raw;

    // Generated period table (4.8 MHz, A4 = note 69 = 440 Hz)
    always_comb begin
        raw = 32'd0;
        case (note_i)
            7'd0:   raw = 32'd587099; 7'd1:   raw = 32'd554147; 7'd2:   raw = 32'd523045; 7'd3:   raw = 32'd493689;
            7'd4:   raw = 32'd465980; 7'd5:   raw = 32'd439827; 7'd6:   raw = 32'd415141; 7'd7:   raw = 32'd391841;
            7'd8:   raw = 32'd369849; 7'd9:   raw = 32'd349091; 7'd10:  raw = 32'd329498; 7'd11:  raw = 32'd311005;
            7'd12:  raw = 32'd293549; 7'd13:  raw = 32'd277074; 7'd14:  raw = 32'd261523; 7'd15:  raw = 32'd246845;
            7'd16:  raw = 32'd232990; 7'd17:  raw = 32'd219913; 7'd18:  raw = 32'd207571; 7'd19:  raw = 32'd195921;
            7'd20:  raw = 32'd184924; 7'd21:  raw = 32'd174545; 7'd22:  raw = 32'd164749; 7'd23:  raw = 32'd155502;
            7'd24:  raw = 32'd146775; 7'd25:  raw = 32'd138537; 7'd26:  raw = 32'd130761; 7'd27:  raw = 32'd123422;
            7'd28:  raw = 32'd116495; 7'd29:  raw = 32'd109957; 7'd30:  raw = 32'd103785; 7'd31:  raw = 32'd97960;
            7'd32:  raw = 32'd92462;  7'd33:  raw = 32'd87273;  7'd34:  raw = 32'd82374;  7'd35:  raw = 32'd77751;
            7'd36:  raw = 32'd73387;  7'd37:  raw = 32'd69268;  7'd38:  raw = 32'd65381;  7'd39:  raw = 32'd61711;
            7'd40:  raw = 32'd58248;  7'd41:  raw = 32'd54978;  7'd42:  raw = 32'd51893;  7'd43:  raw = 32'd48980;
            7'd44:  raw = 32'd46231;  7'd45:  raw = 32'd43636;  7'd46:  raw = 32'd41187;  7'd47:  raw = 32'd38876;
            7'd48:  raw = 32'd36694;  7'd49:  raw = 32'd34634;  7'd50:  raw = 32'd32690;  7'd51:  raw = 32'd30856;
            7'd52:  raw = 32'd29124;  7'd53:  raw = 32'd27489;  7'd54:  raw = 32'd25946;  7'd55:  raw = 32'd24490;
            7'd56:  raw = 32'd23116;  7'd57:  raw = 32'd21818;  7'd58:  raw = 32'd20594;  7'd59:  raw = 32'd19438;
            7'd60:  raw = 32'd18347;  7'd61:  raw = 32'd17317;  7'd62:  raw = 32'd16345;  7'd63:  raw = 32'd15428;
            7'd64:  raw = 32'd14562;  7'd65:  raw = 32'd13745;  7'd66:  raw = 32'd12973;  7'd67:  raw = 32'd12245;
            7'd68:  raw = 32'd11558;  7'd69:  raw = 32'd10909;  7'd70:  raw = 32'd10297;  7'd71:  raw = 32'd9719;
            7'd72:  raw = 32'd9173;   7'd73:  raw = 32'd8659;   7'd74:  raw = 32'd8173;   7'd75:  raw = 32'd7714;
            7'd76:  raw = 32'd7281;   7'd77:  raw = 32'd6872;   7'd78:  raw = 32'd6487;   7'd79:  raw = 32'd6123;
            7'd80:  raw = 32'd5779;   7'd81:  raw = 32'd5455;   7'd82:  raw = 32'd5148;   7'd83:  raw = 32'd4859;
            7'd84:  raw = 32'd4587;   7'd85:  raw = 32'd4329;   7'd86:  raw = 32'd4086;   7'd87:  raw = 32'd3857;
            7'd88:  raw = 32'd3640;   7'd89:  raw = 32'd3436;   7'd90:  raw = 32'd3243;   7'd91:  raw = 32'd3061;
            7'd92:  raw = 32'd2889;   7'd93:  raw = 32'd2727;   7'd94:  raw = 32'd2574;   7'd95:  raw = 32'd2430;
            7'd96:  raw = 32'd2293;   7'd97:  raw = 32'd2165;   7'd98:  raw = 32'd2043;   7'd99:  raw = 32'd1928;
            7'd100: raw = 32'd1820;   7'd101: raw = 32'd1718;   7'd102: raw = 32'd1622;   7'd103: raw = 32'd1531;
            7'd104: raw = 32'd1445;   7'd105: raw = 32'd1364;   7'd106: raw = 32'd1287;   7'd107: raw = 32'd1215;
            7'd108: raw = 32'd1147;   7'd109: raw = 32'd1082;   7'd110: raw = 32'd1022;   7'd111: raw = 32'd964;
            7'd112: raw = 32'd910;    7'd113: raw = 32'd859;    7'd114: raw = 32'd811;    7'd115: raw = 32'd765;
            7'd116: raw = 32'd722;    7'd117: raw = 32'd682;    7'd118: raw = 32'd644;    7'd119: raw = 32'd607;
            7'd120: raw = 32'd573;    7'd121: raw = 32'd541;    7'd122: raw = 32'd511;    7'd123: raw = 32'd482;
            7'd124: raw = 32'd455;    7'd125: raw = 32'd430;    7'd126: raw = 32'd405;    7'd127: raw = 32'd383;
        endcase
    end

    assign period_o = (!TABLE_OK || (raw > PERIOD_MAX)) ? PERIOD_MAX[PERIOD_W-1:0]
                                                        : raw[PERIOD_W-1:0];

endmodule

// File: rtl/midi_note_decoder.sv
// Monophonic MIDI note decoder: turns a UART byte stream into note_on /
// note_off pulses with note number, velocity and waveform period.
// Build option: define MIDI_OMNI_EN to accept note messages on all channels.
//
//  state   | meaning
//  IDLE    | between messages; data bytes used only under running status
//  DATA1   | note-on/off status seen, waiting for note number
//  DATA2   | note number latched, waiting for velocity
//  SKIP1   | one data byte of an unsupported message left to consume
//  SKIP2   | two data bytes of an unsupported message left to consume
module midi_note_decoder
    import midi_note_decoder_pkg::*;
#(
    parameter logic [3:0]  CHANNEL  = 4'd0,
    parameter int unsigned CLK_HZ   = 4800000,
    parameter int          PERIOD_W = 23
) (
    input  logic               clk,
    input  logic               rst,
    midi_note_decoder_if.slave bus
);

    state_e              state_q,    state_d;
    logic                rs_valid_q, rs_valid_d;
    logic                rs_on_q,    rs_on_d;
    logic [NOTE_W-1:0]   note_lat_q, note_lat_d;
    logic                note_on_q,  note_on_d;
    logic                note_off_q, note_off_d;
    logic                active_q,   active_d;
    logic [NOTE_W-1:0]   note_num_q, note_num_d;
    logic [VEL_W-1:0]    velocity_q, velocity_d;
    logic [PERIOD_W-1:0] period_q,   period_d;
    logic [PERIOD_W-1:0] rom_period;
    logic                chan_ok;

`ifdef MIDI_OMNI_EN
    assign chan_ok = 1'b1;
`else
    assign chan_ok = (bus.rx_data[3:0] == CHANNEL);
`endif

    midi_note_decoder_period_rom #(
        .CLK_HZ   (CLK_HZ),
        .PERIOD_W (PERIOD_W)
    ) u_period_rom (
        .note_i   (note_lat_q),
        .period_o (rom_period)
    );

    // Parser next state, running status and note event generation
    always_comb begin
        state_d    = state_q;
        rs_valid_d = rs_valid_q;
        rs_on_d    = rs_on_q;
        note_lat_d = note_lat_q;
        note_on_d  = 1'b0;
        note_off_d = 1'b0;
        active_d   = active_q;
        note_num_d = note_num_q;
        velocity_d = velocity_q;
        period_d   = period_q;

        if (bus.rx_valid) begin
            if (bus.rx_data[7]) begin
                // Real-time bytes (F8..FF) may land anywhere and must not disturb parsing
                if (bus.rx_data[7:3] != 5'b11111) begin
                    rs_valid_d = 1'b0;
                    case (bus.rx_data[7:4])
                        ST_NOTE_OFF, ST_NOTE_ON: begin
                            if (chan_ok) begin
                                rs_valid_d = 1'b1;
                                rs_on_d    = (bus.rx_data[7:4] == ST_NOTE_ON);
                                state_d    = S_DATA1;
                            end else begin
                                state_d    = S_SKIP2;
                            end
                        end
                        ST_POLY_AT, ST_CTRL, ST_PITCH: state_d = S_SKIP2;
                        ST_PROG, ST_CHAN_AT:           state_d = S_SKIP1;
                        ST_SYSTEM:                     state_d = S_IDLE;
                        default:                       state_d = S_IDLE;
                    endcase
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (rs_valid_q) begin
                            note_lat_d = bus.rx_data[6:0];
                            state_d    = S_DATA2;
                        end
                    end
                    S_DATA1: begin
                        note_lat_d = bus.rx_data[6:0];
                        state_d    = S_DATA2;
                    end
                    S_DATA2: begin
                        state_d = S_IDLE;
                        if (rs_on_q && (bus.rx_data[6:0] != 7'd0)) begin
                            note_on_d  = 1'b1;
                            active_d   = 1'b1;
                            note_num_d = note_lat_q;
                            velocity_d = bus.rx_data[6:0];
                            period_d   = rom_period;
                        end else if (active_q && (note_lat_q == note_num_q)) begin
                            note_off_d = 1'b1;
                            active_d   = 1'b0;
                        end
                    end
                    S_SKIP2: state_d = S_SKIP1;
                    S_SKIP1: state_d = S_IDLE;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // State and output registers; reset has priority over any incoming byte
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rs_valid_q <= 1'b0;
            rs_on_q    <= 1'b0;
            note_lat_q <= '0;
            note_on_q  <= 1'b0;
            note_off_q <= 1'b0;
            active_q   <= 1'b0;
            note_num_q <= '0;
            velocity_q <= '0;
            period_q   <= '0;
        end else begin
            state_q    <= state_d;
            rs_valid_q <= rs_valid_d;
            rs_on_q    <= rs_on_d;
            note_lat_q <= note_lat_d;
            note_on_q  <= note_on_d;
            note_off_q <= note_off_d;
            active_q   <= active_d;
            note_num_q <= note_num_d;
            velocity_q <= velocity_d;
            period_q   <= period_d;
        end
    end

    assign bus.note_on  = note_on_q;
    assign bus.note_off = note_off_q;
    assign bus.active   = active_q;
    assign bus.note_num = note_num_q;
    assign bus.velocity = velocity_q;
    assign bus.period   = period_q;

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed bench for midi_note_decoder (CLK_HZ = 4.8 MHz, CHANNEL = 0).
// Each vector drives one cycle of input and lists the outputs expected
// right after the clock edge that samples it.
module tb_midi_note_decoder;
    import midi_note_decoder_pkg::*;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [7:0]  data;
        logic        on;
        logic        off;
        logic        act;
        logic [6:0]  num;
        logic [6:0]  vel;
        logic [22:0] per;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    midi_note_decoder_if #(.PERIOD_W(23)) bus_if ();

    midi_note_decoder #(
        .CHANNEL  (4'd0),
        .CLK_HZ   (4800000),
        .PERIOD_W (23)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    vec_t        vecs[$];
    logic        e_act;
    logic [6:0]  e_num;
    logic [6:0]  e_vel;
    logic [22:0] e_per;
    int          checks = 0;
    int          errors = 0;

    function automatic void push(input logic r, input logic v, input logic [7:0] d,
                                 input logic on, input logic off);
        vec_t x;
        x.rst = r;     x.valid = v;   x.data = d;
        x.on  = on;    x.off = off;   x.act = e_act;
        x.num = e_num; x.vel = e_vel; x.per = e_per;
        vecs.push_back(x);
    endfunction

    function automatic void v_none(input logic [7:0] d);
        push(1'b0, 1'b1, d, 1'b0, 1'b0);
    endfunction

    function automatic void v_gap();
        push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endfunction

    function automatic void v_on(input logic [7:0] d, input logic [6:0] n,
                                 input logic [6:0] v, input logic [22:0] p);
        e_act = 1'b1; e_num = n; e_vel = v; e_per = p;
        push(1'b0, 1'b1, d, 1'b1, 1'b0);
    endfunction

    function automatic void v_off(input logic [7:0] d);
        e_act = 1'b0;
        push(1'b0, 1'b1, d, 1'b0, 1'b1);
    endfunction

    function automatic void v_rst(input logic [7:0] d);
        e_act = 1'b0; e_num = '0; e_vel = '0; e_per = '0;
        push(1'b1, 1'b1, d, 1'b0, 1'b0);
    endfunction

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        e_act = 1'b0; e_num = '0; e_vel = '0; e_per = '0;

        // reset, including reset winning over a valid byte
        v_rst(8'h00); v_rst(8'h90);
        // basic note-on A4
        v_none(8'h90); v_none(8'h45); v_on(8'h64, 7'h45, 7'd100, 23'd10909);
        // running status, then note-on vel 0 for a note that is not held
        v_none(8'h40); v_on(8'h50, 7'h40, 7'd80, 23'd14562);
        v_none(8'h45); v_none(8'h00);
        // note-off for the held note, then a repeat that must be ignored
        v_none(8'h80); v_none(8'h40); v_off(8'h00);
        v_none(8'h80); v_none(8'h40); v_none(8'h00);
        // wrong channel (accepted only in omni builds)
        v_none(8'h91); v_none(8'h45);
`ifdef MIDI_OMNI_EN
        v_on(8'h64, 7'h45, 7'd100, 23'd10909);
        v_none(8'h81); v_none(8'h45); v_off(8'h00);
`else
        v_none(8'h64);
        v_none(8'h81); v_none(8'h45); v_none(8'h00);
`endif
        // program change skips one byte and clears running status
        v_none(8'hC0); v_none(8'h05); v_none(8'h45); v_none(8'h10);
        // real-time bytes inside a message
        v_none(8'h90); v_none(8'hF8); v_none(8'h3C); v_none(8'hFE);
        v_on(8'h7F, 7'h3C, 7'd127, 23'd18347);
        // note-on with velocity 0 releases
        v_none(8'h3C); v_off(8'h00);
        // two-byte unsupported messages, data afterwards discarded
        v_none(8'hA0); v_none(8'h3C); v_none(8'h40); v_none(8'h3C); v_none(8'h50);
        v_none(8'hE0); v_none(8'h00); v_none(8'h40); v_none(8'h3C); v_none(8'h50);
        // status byte aborting a message mid-way
        v_none(8'h90); v_none(8'h3C); v_none(8'h91); v_none(8'h3C); v_none(8'h40);
        v_none(8'h48); v_none(8'h7F);
        // idle gaps and real-time while waiting for velocity
        v_none(8'h90); v_none(8'h48); v_gap(); v_none(8'hFF); v_gap();
        v_on(8'h7F, 7'h48, 7'd127, 23'd9173);
        // note-off with nonzero release velocity keeps stored velocity
        v_none(8'h80); v_none(8'h48); v_off(8'h10);
        // sysex clears running status
        v_none(8'h90); v_none(8'h30); v_on(8'h20, 7'h30, 7'd32, 23'd36694);
        v_none(8'hF0); v_none(8'h30); v_none(8'h00); v_none(8'hF7);
        v_none(8'h80); v_none(8'h30); v_off(8'h40);
        // table extremes, running status between them
        v_none(8'h90); v_none(8'h00); v_on(8'h01, 7'h00, 7'd1, 23'd587099);
        v_none(8'h7F); v_on(8'h7F, 7'h7F, 7'd127, 23'd383);
        v_none(8'h80); v_none(8'h00); v_none(8'h00);
        // retrigger while held, old note's release then ignored
        v_none(8'h90); v_none(8'h40); v_on(8'h50, 7'h40, 7'd80, 23'd14562);
        v_none(8'h80); v_none(8'h7F); v_none(8'h00);
        // reset mid-message clears running status
        v_none(8'h90); v_rst(8'h45); v_none(8'h45); v_none(8'h64);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst             = vecs[i].rst;
            bus_if.rx_valid = vecs[i].valid;
            bus_if.rx_data  = vecs[i].data;
            @(posedge clk);
            #1;
            checks++;
            if ({bus_if.note_on, bus_if.note_off, bus_if.active, bus_if.note_num,
                 bus_if.velocity, bus_if.period} !==
                {vecs[i].on, vecs[i].off, vecs[i].act, vecs[i].num, vecs[i].vel, vecs[i].per}) begin
                errors++;
                $display("FAIL vec%0d byte=%h: got on=%b off=%b act=%b num=%h vel=%0d per=%0d, want on=%b off=%b act=%b num=%h vel=%0d per=%0d",
                         i, vecs[i].data, bus_if.note_on, bus_if.note_off, bus_if.active,
                         bus_if.note_num, bus_if.velocity, bus_if.period,
                         vecs[i].on, vecs[i].off, vecs[i].act, vecs[i].num, vecs[i].vel, vecs[i].per);
            end
        end

        // latency and pulse width of a single note-on
        @(negedge clk); rst = 1'b0; bus_if.rx_valid = 1'b1; bus_if.rx_data = 8'h90;
        @(negedge clk); bus_if.rx_data = 8'h3C;
        @(negedge clk); bus_if.rx_data = 8'h50;
        #1;
        check_val("no_pulse_before_edge", int'(bus_if.note_on), 0);
        @(posedge clk); #1;
        check_val("pulse_after_edge", int'(bus_if.note_on), 1);
        check_val("pulse_period", int'(bus_if.period), 18347);
        @(negedge clk); bus_if.rx_valid = 1'b0; bus_if.rx_data = 8'h00;
        @(posedge clk); #1;
        check_val("pulse_one_cycle", int'(bus_if.note_on), 0);
        check_val("active_held", int'(bus_if.active), 1);
        check_val("velocity_held", int'(bus_if.velocity), 80);
        repeat (3) @(posedge clk);
        #1;
        check_val("note_num_held", int'(bus_if.note_num), 8'h3C);
        check_val("no_spurious_off", int'(bus_if.note_off), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
